// File: rtl/digit_bbox_pkg.sv
// Shared defaults for the number-recognition pipeline stages and the bbox FSM encoding.
package digit_bbox_pkg;

    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_XW         = 10;
    localparam int unsigned DEF_YW         = 9;
    localparam int unsigned DEF_CW         = 19;
    localparam int unsigned DEF_MIN_PIXELS = 64;

    typedef enum logic {
        SYNC  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/digit_bbox_minmax.sv
// Running min/max register pair; clear (or reset) reloads the init values.
module bbox_minmax #(
    parameter int unsigned    W        = 10,
    parameter logic [W-1:0]   INIT_MIN = '1,
    parameter logic [W-1:0]   INIT_MAX = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         upd_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] min_o,
    output logic [W-1:0] max_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            min_o <= INIT_MIN;
            max_o <= INIT_MAX;
        end else if (upd_i) begin
            if (val_i < min_o) min_o <= val_i;
            if (val_i > max_o) max_o <= val_i;
        end
    end

endmodule

// File: rtl/digit_bbox.sv
// Per-frame bounding box, pixel count and found flag of the binarised foreground.
module digit_bbox
    import digit_bbox_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned XW         = DEF_XW,
    parameter int unsigned YW         = DEF_YW,
    parameter int unsigned CW         = DEF_CW,
    parameter int unsigned MIN_PIXELS = DEF_MIN_PIXELS
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          vsync_i,
    input  logic          href_i,
    input  logic          binary_i,
    output logic          box_valid_o,
    output logic          found_o,
    output logic [XW-1:0] x0_o,
    output logic [XW-1:0] x1_o,
    output logic [YW-1:0] y0_o,
    output logic [YW-1:0] y1_o,
    output logic [CW-1:0] pix_cnt_o
);

    localparam logic [XW-1:0] X_END   = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_END   = YW'(V_ACTIVE);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_PIXELS);

    state_e        state_q;
    logic          vsync_q, href_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] xmin, xmax;
    logic [YW-1:0] ymin, ymax;
    logic          vs_rise, hr_fall, in_range, hit, found;

    assign vs_rise  = vsync_i & ~vsync_q;
    assign hr_fall  = ~href_i & href_q;
    assign in_range = href_i & (x_q < X_END) & (y_q < Y_END) & ~vsync_i;
    assign hit      = (state_q == ACCUM) & in_range & binary_i;
    assign found    = (cnt_q >= CNT_MIN);

    // x/y saturate one past the active area so overlong lines/frames stay out of range
    always_comb begin
        x_d = x_q;
        if (hr_fall)
            x_d = '0;
        else if (href_i && x_q != X_END)
            x_d = x_q + 1'b1;

        y_d = y_q;
        if (vs_rise)
            y_d = '0;
        else if (hr_fall && y_q != Y_END)
            y_d = y_q + 1'b1;

        cnt_d = cnt_q;
        if (vs_rise)
            cnt_d = '0;
        else if (hit && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    bbox_minmax #(
        .W        (XW),
        .INIT_MIN (XW'(H_ACTIVE - 1)),
        .INIT_MAX ('0)
    ) u_xmm (
        .clk_i  (pclk),
        .rst_ni (rst_n),
        .clr_i  (vs_rise),
        .upd_i  (hit),
        .val_i  (x_q),
        .min_o  (xmin),
        .max_o  (xmax)
    );

    bbox_minmax #(
        .W        (YW),
        .INIT_MIN (YW'(V_ACTIVE - 1)),
        .INIT_MAX ('0)
    ) u_ymm (
        .clk_i  (pclk),
        .rst_ni (rst_n),
        .clr_i  (vs_rise),
        .upd_i  (hit),
        .val_i  (y_q),
        .min_o  (ymin),
        .max_o  (ymax)
    );

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            box_valid_o <= 1'b0;
            found_o     <= 1'b0;
            x0_o        <= '0;
            x1_o        <= '0;
            y0_o        <= '0;
            y1_o        <= '0;
            pix_cnt_o   <= '0;
        end else begin
            vsync_q     <= vsync_i;
            href_q      <= href_i;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            box_valid_o <= 1'b0;
            case (state_q)
                SYNC: begin
                    if (vs_rise) state_q <= ACCUM;
                end
                ACCUM: begin
                    if (vs_rise) begin
                        box_valid_o <= 1'b1;
                        pix_cnt_o   <= cnt_q;
                        found_o     <= found;
                        x0_o        <= found ? xmin : '0;
                        x1_o        <= found ? xmax : '0;
                        y0_o        <= found ? ymin : '0;
                        y1_o        <= found ? ymax : '0;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

endmodule
